irq_pending_arbiter: RTL

//   Captures rising edges on N request lines into a sticky pending register.

---
 rtl/irq_pending_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/irq_pending_arbiter.sv
// Edge-captures N request lines into a sticky pending vector and hands the
// pending requests out one at a time, highest index first, over valid/ready.
module irq_pending_arbiter #(
   parameter int N    = 8,
   parameter int IDXW = 3,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N-1:0]    req,
   input  logic            clr_all,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [IDXW-1:0] out_idx,
   output logic [N-1:0]    pending,
   output logic [CNTW-1:0] dropped
);

   typedef enum logic {IDLE, PRESENT} state_t;

   state_t          state_q,     state_d;
   logic [N-1:0]    req_q,       req_d;
   logic [N-1:0]    pending_q,   pending_d;
   logic [IDXW-1:0] out_idx_q,   out_idx_d;
   logic            out_valid_q, out_valid_d;
   logic [CNTW-1:0] dropped_q,   dropped_d;

   logic [N-1:0]    rise;
   logic [N-1:0]    drop_vec;
   logic [N-1:0]    clr_mask;
   logic            accept;

   function automatic logic [IDXW:0] popcount(input logic [N-1:0] v);
      logic [IDXW:0] c;
      c = '0;
      for (int i = 0; i < N; i++) c = c + {{IDXW{1'b0}}, v[i]};
      return c;
   endfunction

   // Ascending scan with last-hit-wins yields the highest set index.
   function automatic logic [IDXW-1:0] hi_index(input logic [N-1:0] v);
      logic [IDXW-1:0] idx;
      idx = '0;
      for (int i = 0; i < N; i++) if (v[i]) idx = i[IDXW-1:0];
      return idx;
   endfunction

   function automatic logic [CNTW-1:0] sat_add(input logic [CNTW-1:0] a,
                                                input logic [IDXW:0]   b);
      logic [CNTW:0] sum;
      sum = {1'b0, a} + {{(CNTW-IDXW){1'b0}}, b};
      return sum[CNTW] ? {CNTW{1'b1}} : sum[CNTW-1:0];
   endfunction

   always_comb begin
      rise     = req & ~req_q;
      accept   = out_valid_q & out_ready;
      clr_mask = '0;
      if (accept) clr_mask[out_idx_q] = 1'b1;
      drop_vec = rise & pending_q;

      req_d       = req;
      pending_d   = (pending_q & ~clr_mask) | rise;
      dropped_d   = sat_add(dropped_q, popcount(drop_vec));
      out_idx_d   = out_idx_q;
      out_valid_d = out_valid_q;
      state_d     = state_q;

      case (state_q)
         IDLE: begin
            if (pending_q != '0) begin
               out_idx_d   = hi_index(pending_q);
               out_valid_d = 1'b1;
               state_d     = PRESENT;
            end
         end
         PRESENT: begin
            if (accept) begin
               out_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase

      // Flush wins over everything; edges seen now are discarded, not dropped.
      if (clr_all) begin
         pending_d   = '0;
         dropped_d   = dropped_q;
         out_valid_d = 1'b0;
         state_d     = IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         req_q       <= '0;
         pending_q   <= '0;
         out_idx_q   <= '0;
         out_valid_q <= 1'b0;
         dropped_q   <= '0;
      end else begin
         state_q     <= state_d;
         req_q       <= req_d;
         pending_q   <= pending_d;
         out_idx_q   <= out_idx_d;
         out_valid_q <= out_valid_d;
         dropped_q   <= dropped_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_idx   = out_idx_q;
   assign pending   = pending_q;
   assign dropped   = dropped_q;

endmodule
